count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, counter and limit width in bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 tick  input  1  count-enable strobe; one count step per sampled-high cycle in RUN.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accept; command executes when cmd_valid && cmd_ready.
REQ-007 cmd_op  input  2  00 SET_LIMIT, 01 START, 10 PAUSE (toggle), 11 STOP.
REQ-008 cmd_data  input  WIDTH  SET_LIMIT: new limit; START: bit0 = periodic mode (1) / one-shot (0); otherwise ignored.
REQ-009 count  output  WIDTH  current counter value.
REQ-010 state  output  2  00 IDLE, 01 RUN, 10 PAUSED; 11 never driven.
REQ-011 busy  output  1  high in RUN or PAUSED.
REQ-012 done  output  1  one-cycle pulse on terminal count.
REQ-013 wrap  output  1  one-cycle pulse when periodic mode restarts from 0.
REQ-014 err  output  1  one-cycle pulse on an illegal command (accepted, otherwise ignored).

Function
REQ-015 cmd_ready SHALL be 1 in every cycle with rst_n high, and 0 while rst_n is low.
REQ-016 All outputs SHALL be registered; a command or tick sampled at edge N SHALL be visible on outputs after edge N.
REQ-017 SET_LIMIT in IDLE SHALL load limit = cmd_data; in RUN/PAUSED SHALL pulse err and leave limit unchanged.
REQ-018 START in any state SHALL set count = 0, latch periodic = cmd_data[0], enter RUN; no err.
REQ-019 PAUSE SHALL move RUN -> PAUSED and PAUSED -> RUN with count held; in IDLE SHALL pulse err.
REQ-020 STOP in any state SHALL enter IDLE and clear count to 0; no done or wrap.
REQ-021 In RUN with tick=1 and count != limit, count SHALL increment by 1 (modulo 2^WIDTH not reachable since count <= limit).
REQ-022 In RUN with tick=1 and count == limit, done SHALL pulse; one-shot: enter IDLE, count holds limit; periodic: count = 0, wrap pulses with done, stay RUN.
REQ-023 limit = 0: first tick after START SHALL give done (and wrap if periodic) with count remaining 0.
REQ-024 tick SHALL be ignored in IDLE and PAUSED.
REQ-025 When a command is accepted in the same cycle as tick, the command SHALL take effect and the tick SHALL be discarded (no count, done, or wrap).
REQ-026 done, wrap, err SHALL be low in every cycle without their triggering event; never asserted two consecutive cycles from one event.
REQ-027 busy SHALL equal (state == RUN || state == PAUSED) in every cycle.

Reset
REQ-028 With rst_n low at a rising edge: state = IDLE, count = 0, limit = all ones (255 for WIDTH 8), periodic = 0, done = wrap = err = 0, busy = 0.
REQ-029 Reset SHALL override any concurrent command or tick, including mid-RUN and mid-PAUSED.

Verification
REQ-030 SET_LIMIT 3, START data 0, tick held high -> count 1,2,3; done pulses once on the edge after count reached 3; state IDLE, count stays 3, busy 0.
REQ-031 SET_LIMIT 2, START data 1, tick high 7 cycles -> count 1,2,0,1,2,0,1; done and wrap pulse together on both wrap cycles; state stays RUN.
REQ-032 Running at count 5, PAUSE -> state PAUSED, count 5 held for 4 ticks; PAUSE again -> RUN, next tick gives 6; PAUSE in IDLE -> err pulse, state IDLE.
REQ-033 In RUN, SET_LIMIT 9 -> err pulse, limit unchanged (verify via terminal count); START with tick in same cycle at count 4 -> count 0, no step.
REQ-034 SET_LIMIT 0, START data 0, one tick -> done pulse, count 0, IDLE; reset default limit: START after reset counts to 255 then done.
REQ-035 rst_n low for one cycle while RUN at count 7 with cmd_valid and tick high -> all outputs reset values per REQ-028, cmd_ready 0 during reset.

Source files
------------

// File: rtl/count_sequencer.sv
// Command-driven up-counter with limit, one-shot/periodic modes and pause; outputs registered, 1-cycle latency.
// Commands are accepted every cycle outside reset (cmd_ready follows rst_n); no backpressure on tick.
module count_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_SET_LIMIT = 2'b00,
        OP_START     = 2'b01,
        OP_PAUSE     = 2'b10,
        OP_STOP      = 2'b11
    } op_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic             periodic_q;
    logic             busy_q;
    logic             done_q;
    logic             wrap_q;
    logic             err_q;
    logic             cmd_fire;
    op_t              op;

    // Ready is a direct function of reset so it is low for exactly the reset cycles.
    assign cmd_ready = rst_n;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign op        = op_t'(cmd_op);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            limit_q    <= '1;
            periodic_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            // An accepted command always wins over a concurrent tick.
            if (cmd_fire) begin
                case (op)
                    OP_SET_LIMIT: begin
                        if (state_q == ST_IDLE) begin
                            limit_q <= cmd_data;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    OP_START: begin
                        count_q    <= '0;
                        periodic_q <= cmd_data[0];
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                    end
                    OP_PAUSE: begin
                        if (state_q == ST_RUN) begin
                            state_q <= ST_PAUSED;
                        end else if (state_q == ST_PAUSED) begin
                            state_q <= ST_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else if (state_q == ST_RUN && tick) begin
                if (count_q == limit_q) begin
                    done_q <= 1'b1;
                    if (periodic_q) begin
                        count_q <= '0;
                        wrap_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    count_q <= count_q + WIDTH'(1);
                end
            end
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign err   = err_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: hand-computed expectations, sampled 1ns after each rising edge.
module tb_count_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] count;
    logic [1:0] state;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;

    int n_cmp;
    int n_bad;

    localparam logic [1:0] SET = 2'b00, START = 2'b01, PAUSE = 2'b10, STOP = 2'b11;

    count_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count     (count),
        .state     (state),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_data  = 8'd0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0] per_cnt [7] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1};
    logic       per_pls [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; tick = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'd0;
        step(); step();
        chk("rst_state", 32'(state), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pulses", 32'({done, wrap, err}), 0);
        chk("rst_ready", 32'(cmd_ready), 0);

        // default limit 255
        rst_n = 1'b1;
        cmd(START, 8'd0);
        chk("ready_up", 32'(cmd_ready), 1);
        chk("start_state", 32'(state), 1);
        chk("start_busy", 32'(busy), 1);
        ticks(255);
        chk("def_cnt255", 32'(count), 255);
        chk("def_nodone", 32'(done), 0);
        step();
        chk("def_done", 32'(done), 1);
        chk("def_idle", 32'(state), 0);
        chk("def_hold", 32'(count), 255);
        step();
        chk("def_done_once", 32'(done), 0);
        tick = 1'b0;

        // one-shot, limit 3
        cmd(SET, 8'd3);
        cmd(START, 8'd0);
        tick = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("os_cnt", 32'(count), 32'(i));
            chk("os_nodone", 32'(done), 0);
        end
        step();
        chk("os_done", 32'(done), 1);
        chk("os_idle", 32'(state), 0);
        chk("os_cnt3", 32'(count), 3);
        chk("os_busy", 32'(busy), 0);
        step();
        chk("os_done_once", 32'(done), 0);
        chk("os_ign_tick", 32'(count), 3);
        tick = 1'b0;

        // periodic, limit 2
        cmd(SET, 8'd2);
        cmd(START, 8'd1);
        tick = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("per_cnt", 32'(count), 32'(per_cnt[i]));
            chk("per_done", 32'(done), 32'(per_pls[i]));
            chk("per_wrap", 32'(wrap), 32'(per_pls[i]));
        end
        chk("per_run", 32'(state), 1);

        // pause / resume at count 5
        tick = 1'b0;
        cmd(STOP, 8'd0);
        chk("stop_idle", 32'(state), 0);
        chk("stop_cnt", 32'(count), 0);
        cmd(SET, 8'd20);
        cmd(START, 8'd0);
        ticks(5);
        chk("pre_pause", 32'(count), 5);
        tick = 1'b0;
        cmd(PAUSE, 8'd0);
        chk("paused", 32'(state), 2);
        chk("paused_busy", 32'(busy), 1);
        ticks(4);
        chk("paused_hold", 32'(count), 5);
        cmd(PAUSE, 8'd0);
        chk("resumed", 32'(state), 1);
        chk("resume_cnt", 32'(count), 5);
        step();
        chk("resume_step", 32'(count), 6);

        // SET_LIMIT while running is rejected
        tick = 1'b0;
        cmd(SET, 8'd9);
        chk("set_run_err", 32'(err), 1);
        chk("set_run_state", 32'(state), 1);
        step();
        chk("err_once", 32'(err), 0);
        cmd(START, 8'd0);
        ticks(4);
        chk("pre_restart", 32'(count), 4);
        cmd(START, 8'd0);
        chk("restart_cnt", 32'(count), 0);
        chk("restart_nodone", 32'(done), 0);
        ticks(10);
        chk("lim_kept_cnt", 32'(count), 10);
        chk("lim_kept_nodone", 32'(done), 0);
        ticks(10);
        chk("lim20_cnt", 32'(count), 20);
        step();
        chk("lim20_done", 32'(done), 1);
        chk("lim20_idle", 32'(state), 0);
        tick = 1'b0;

        // PAUSE in IDLE
        cmd(PAUSE, 8'd0);
        chk("pause_idle_err", 32'(err), 1);
        chk("pause_idle_state", 32'(state), 0);
        step();
        chk("pause_idle_err_once", 32'(err), 0);

        // limit 0
        cmd(SET, 8'd0);
        cmd(START, 8'd0);
        step();
        chk("l0_notick", 32'(done), 0);
        ticks(1);
        chk("l0_done", 32'(done), 1);
        chk("l0_cnt", 32'(count), 0);
        chk("l0_idle", 32'(state), 0);
        chk("l0_nowrap", 32'(wrap), 0);
        tick = 1'b0;
        cmd(START, 8'd1);
        ticks(1);
        chk("l0p_pulses", 32'({done, wrap}), 3);
        chk("l0p_run", 32'(state), 1);
        cmd(STOP, 8'd0);
        chk("stop_tick_pulses", 32'({done, wrap}), 0);
        chk("stop_tick_idle", 32'(state), 0);
        tick = 1'b0;

        // reset mid-run at count 7
        cmd(SET, 8'd20);
        cmd(START, 8'd1);
        ticks(7);
        chk("pre_rst_cnt", 32'(count), 7);
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = PAUSE; tick = 1'b1;
        #1;
        chk("rst_ready_low", 32'(cmd_ready), 0);
        step();
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pulses", 32'({done, wrap, err}), 0);
        rst_n = 1'b1; cmd_valid = 1'b0;
        step();
        chk("post_rst_idle", 32'(state), 0);
        chk("post_rst_cnt", 32'(count), 0);
        tick = 1'b0;
        cmd(START, 8'd0);
        ticks(255);
        chk("post_rst_lim_cnt", 32'(count), 255);
        step();
        chk("post_rst_lim_done", 32'(done), 1);
        chk("post_rst_oneshot", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
